// File: rtl/timing_control.sv
// timing_control: 6502 timing/IR stage; holds IR and TCU for the decoder,
// injects BRK for reset/NMI/IRQ and stalls read cycles on RDY.
//
// Ports:
//   i_clk          core clock, rising edge
//   i_reset        synchronous active-high reset
//   i_data   [7:0] data bus, sampled as opcode when TCU==0
//   i_rdy          ready; low stalls read cycles only
//   i_rw           decoder cycle direction (1 read, 0 write)
//   i_tcu_next [2:0] decoder next TCU
//   i_last_cycle   decoder: current cycle ends the instruction
//   i_nmi          NMI request, rising-edge triggered
//   i_irq          IRQ request, level sensitive
//   i_i_flag       I flag, masks IRQ
//   o_ir     [7:0] current opcode
//   o_tcu    [2:0] current cycle index
//   o_sync         opcode fetch cycle (TCU==0)
//   o_int_kind [1:0] 0 fetched, 1 IRQ, 2 NMI, 3 RESET
//   o_tcu_overflow one-clock pulse after TCU wrapped without last cycle
module timing_control #(
    parameter logic [7:0] BRK_OPCODE = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data,
    input  logic       i_rdy,
    input  logic       i_rw,
    input  logic [2:0] i_tcu_next,
    input  logic       i_last_cycle,
    input  logic       i_nmi,
    input  logic       i_irq,
    input  logic       i_i_flag,
    output logic [7:0] o_ir,
    output logic [2:0] o_tcu,
    output logic       o_sync,
    output logic [1:0] o_int_kind,
    output logic       o_tcu_overflow
);

    localparam logic [1:0] KIND_FETCH = 2'd0;
    localparam logic [1:0] KIND_IRQ   = 2'd1;
    localparam logic [1:0] KIND_NMI   = 2'd2;
    localparam logic [1:0] KIND_RESET = 2'd3;

    logic [7:0] r_ir;
    logic [2:0] r_tcu;
    logic [1:0] r_int_kind;
    logic       r_tcu_overflow;
    logic       r_nmi_pending;
    logic       r_nmi_prev;

    logic       w_advance;
    logic       w_fetch;
    logic       w_nmi_edge;
    logic       w_irq_take;

    // RDY only stalls reads; writes always complete.
    assign w_advance  = i_rdy | ~i_rw;
    assign w_fetch    = (r_tcu == 3'd0) & w_advance;
    assign w_nmi_edge = i_nmi & ~r_nmi_prev;
    assign w_irq_take = i_irq & ~i_i_flag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ir           <= BRK_OPCODE;
            r_tcu          <= 3'd1;
            r_int_kind     <= KIND_RESET;
            r_tcu_overflow <= 1'b0;
            r_nmi_pending  <= 1'b0;
            // Prev starts high so an NMI held across reset is not an edge.
            r_nmi_prev     <= 1'b1;
        end else begin
            r_nmi_prev     <= i_nmi;
            r_tcu_overflow <= 1'b0;

            // A new edge wins over the clear from injection.
            if (w_nmi_edge) begin
                r_nmi_pending <= 1'b1;
            end else if (w_fetch && r_nmi_pending) begin
                r_nmi_pending <= 1'b0;
            end

            if (w_advance) begin
                if (r_tcu == 3'd0) begin
                    r_tcu <= 3'd1;
                    if (r_nmi_pending) begin
                        r_ir       <= BRK_OPCODE;
                        r_int_kind <= KIND_NMI;
                    end else if (w_irq_take) begin
                        r_ir       <= BRK_OPCODE;
                        r_int_kind <= KIND_IRQ;
                    end else begin
                        r_ir       <= i_data;
                        r_int_kind <= KIND_FETCH;
                    end
                end else if (i_last_cycle) begin
                    r_tcu <= 3'd0;
                end else if (r_tcu == 3'd7) begin
                    // Decoder never ended the instruction; force a fetch.
                    r_tcu          <= 3'd0;
                    r_tcu_overflow <= 1'b1;
                end else begin
                    r_tcu <= i_tcu_next;
                end
            end
        end
    end

    assign o_ir           = r_ir;
    assign o_tcu          = r_tcu;
    assign o_sync         = (r_tcu == 3'd0);
    assign o_int_kind     = r_int_kind;
    assign o_tcu_overflow = r_tcu_overflow;

endmodule

// File: tb/tb_timing_control.sv
// tb_timing_control: directed self-checking bench for timing_control.
// The bench acts as the decoder, driving i_tcu_next / i_last_cycle per cycle.
module tb_timing_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       rdy = 1'b1;
    logic       rw = 1'b1;
    logic [2:0] tnext = 3'd0;
    logic       last = 1'b0;
    logic       nmi = 1'b0;
    logic       irq = 1'b0;
    logic       iflag = 1'b1;
    logic [7:0] ir;
    logic [2:0] tcu;
    logic       sync;
    logic [1:0] kind;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timing_control #(.BRK_OPCODE(8'h00)) dut (
        .i_clk(clk), .i_reset(rst), .i_data(data), .i_rdy(rdy),
        .i_rw(rw), .i_tcu_next(tnext), .i_last_cycle(last),
        .i_nmi(nmi), .i_irq(irq), .i_i_flag(iflag),
        .o_ir(ir), .o_tcu(tcu), .o_sync(sync), .o_int_kind(kind),
        .o_tcu_overflow(ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; nmi = 1'b1;
        step(); step();
        checks++; if (ir !== 8'h00) begin errors++; $display("FAIL rst_ir got=%h exp=00", ir); end
        checks++; if (tcu !== 3'd1) begin errors++; $display("FAIL rst_tcu got=%0d exp=1", tcu); end
        checks++; if (kind !== 2'd3) begin errors++; $display("FAIL rst_kind got=%0d exp=3", kind); end
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL rst_sync got=%b exp=0", sync); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        rst = 1'b0; last = 1'b1;
        step();
        checks++; if (tcu !== 3'd0 || sync !== 1'b1) begin errors++; $display("FAIL rst_tofetch tcu=%0d sync=%b exp=0,1", tcu, sync); end
        data = 8'hEA; last = 1'b0;
        step();
        checks++; if (ir !== 8'hEA || kind !== 2'd0) begin errors++; $display("FAIL rst_no_nmi ir=%h kind=%0d exp=EA,0", ir, kind); end
        nmi = 1'b0; last = 1'b1;
        step();
    endtask

    task automatic test_sta();
        data = 8'h8D; last = 1'b0; tnext = 3'd1;
        step();
        checks++; if (ir !== 8'h8D || tcu !== 3'd1 || sync !== 1'b0 || kind !== 2'd0) begin errors++; $display("FAIL sta_t1 ir=%h tcu=%0d sync=%b kind=%0d exp=8D,1,0,0", ir, tcu, sync, kind); end
        data = 8'hFF; tnext = 3'd2;
        step();
        checks++; if (tcu !== 3'd2 || sync !== 1'b0) begin errors++; $display("FAIL sta_t2 tcu=%0d sync=%b exp=2,0", tcu, sync); end
        tnext = 3'd3;
        step();
        checks++; if (tcu !== 3'd3 || ir !== 8'h8D) begin errors++; $display("FAIL sta_t3 tcu=%0d ir=%h exp=3,8D", tcu, ir); end
        last = 1'b1;
        step();
        checks++; if (tcu !== 3'd0 || sync !== 1'b1 || ir !== 8'h8D) begin errors++; $display("FAIL sta_t0 tcu=%0d sync=%b ir=%h exp=0,1,8D", tcu, sync, ir); end
    endtask

    task automatic test_rdy();
        data = 8'hAD; last = 1'b0;
        step();
        tnext = 3'd2;
        step();
        checks++; if (tcu !== 3'd2) begin errors++; $display("FAIL rdy_pre tcu=%0d exp=2", tcu); end
        rdy = 1'b0; rw = 1'b1; tnext = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (tcu !== 3'd2) begin errors++; $display("FAIL rdy_stall%0d tcu=%0d exp=2", i, tcu); end
        end
        rdy = 1'b1;
        step();
        checks++; if (tcu !== 3'd3) begin errors++; $display("FAIL rdy_resume tcu=%0d exp=3", tcu); end
        rdy = 1'b0; rw = 1'b0; last = 1'b1;
        step();
        checks++; if (tcu !== 3'd0) begin errors++; $display("FAIL rdy_write tcu=%0d exp=0", tcu); end
        rdy = 1'b1; rw = 1'b1; last = 1'b0;
    endtask

    task automatic test_nmi();
        data = 8'hAD;
        step();
        tnext = 3'd2;
        step();
        nmi = 1'b1; tnext = 3'd3;
        step();
        nmi = 1'b0; last = 1'b1;
        step();
        data = 8'hA9; last = 1'b0;
        step();
        checks++; if (ir !== 8'h00 || kind !== 2'd2 || tcu !== 3'd1) begin errors++; $display("FAIL nmi_inject ir=%h kind=%0d tcu=%0d exp=00,2,1", ir, kind, tcu); end
        last = 1'b1;
        step();
        checks++; if (kind !== 2'd2) begin errors++; $display("FAIL nmi_kind_hold kind=%0d exp=2", kind); end
        last = 1'b0;
        step();
        checks++; if (ir !== 8'hA9 || kind !== 2'd0) begin errors++; $display("FAIL nmi_cleared ir=%h kind=%0d exp=A9,0", ir, kind); end
        last = 1'b1;
        step();
    endtask

    task automatic test_irq();
        irq = 1'b1; iflag = 1'b1; data = 8'h58; last = 1'b0;
        step();
        checks++; if (ir !== 8'h58 || kind !== 2'd0) begin errors++; $display("FAIL irq_masked ir=%h kind=%0d exp=58,0", ir, kind); end
        last = 1'b1;
        step();
        iflag = 1'b0; last = 1'b0;
        step();
        checks++; if (ir !== 8'h00 || kind !== 2'd1) begin errors++; $display("FAIL irq_taken ir=%h kind=%0d exp=00,1", ir, kind); end
        nmi = 1'b1; last = 1'b1;
        step();
        nmi = 1'b0; last = 1'b0;
        step();
        checks++; if (ir !== 8'h00 || kind !== 2'd2) begin errors++; $display("FAIL nmi_over_irq ir=%h kind=%0d exp=00,2", ir, kind); end
        irq = 1'b0; iflag = 1'b1; last = 1'b1;
        step();
    endtask

    task automatic test_overflow();
        data = 8'hEA; last = 1'b0;
        step();
        for (int t = 2; t <= 7; t++) begin
            tnext = 3'(t);
            step();
            checks++; if (tcu !== 3'(t) || ovf !== 1'b0) begin errors++; $display("FAIL ovf_run tcu=%0d ovf=%b exp=%0d,0", tcu, ovf, t); end
        end
        tnext = 3'd7;
        step();
        checks++; if (tcu !== 3'd0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_wrap tcu=%0d ovf=%b exp=0,1", tcu, ovf); end
        step();
        checks++; if (tcu !== 3'd1 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse tcu=%0d ovf=%b exp=1,0", tcu, ovf); end
        last = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        data = 8'h8D; last = 1'b0; tnext = 3'd2;
        step();
        nmi = 1'b1;
        step();
        nmi = 1'b0; tnext = 3'd3;
        step();
        checks++; if (tcu !== 3'd3 || ir !== 8'h8D) begin errors++; $display("FAIL mid_pre tcu=%0d ir=%h exp=3,8D", tcu, ir); end
        rst = 1'b1;
        step();
        checks++; if (ir !== 8'h00 || tcu !== 3'd1 || kind !== 2'd3 || sync !== 1'b0) begin errors++; $display("FAIL mid_reset ir=%h tcu=%0d kind=%0d sync=%b exp=00,1,3,0", ir, tcu, kind, sync); end
        rst = 1'b0; last = 1'b1;
        step();
        data = 8'hA9; last = 1'b0;
        step();
        checks++; if (ir !== 8'hA9 || kind !== 2'd0) begin errors++; $display("FAIL mid_nmi_cleared ir=%h kind=%0d exp=A9,0", ir, kind); end
    endtask

    initial begin
        test_reset();
        test_sta();
        test_rdy();
        test_nmi();
        test_irq();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timing_control.md
# timing_control

Timing-control and instruction-register stage of the 6502 core. It sits directly upstream of the opcode decoder. It holds the current opcode (IR) and cycle counter (TCU), and presents both to the decoder, which returns the next TCU value and an end-of-instruction flag. It also injects the forced BRK opcode used for the reset, NMI and IRQ sequences, and stalls on RDY.

## Interface
Parameters:
- `BRK_OPCODE`, default 8'h00, opcode forced into IR for reset/interrupt sequences.

Ports:
- `i_clk`  in  1  core clock; all state updates on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_data`  in  8  data bus; sampled as the opcode when TCU==0.
- `i_rdy`  in  1  ready; low stalls read cycles only.
- `i_rw`  in  1  current cycle direction from the decoder (1 = read, 0 = write).
- `i_tcu_next`  in  3  decoder's next TCU value.
- `i_last_cycle`  in  1  decoder flag: the current cycle is the final cycle of the instruction.
- `i_nmi`  in  1  NMI request, active high, rising-edge triggered.
- `i_irq`  in  1  IRQ request, active high, level sensitive.
- `i_i_flag`  in  1  processor I flag; 1 masks IRQ.
- `o_ir`  out  8  current opcode.
- `o_tcu`  out  3  current cycle index within the instruction.
- `o_sync`  out  1  high when `o_tcu`==0 (opcode fetch cycle).
- `o_int_kind`  out  2  source of the current instruction: 0 fetched, 1 IRQ, 2 NMI, 3 RESET.
- `o_tcu_overflow`  out  1  one-cycle pulse when TCU wrapped without `i_last_cycle`.

## Operation
- `advance` = `i_rdy` | ~`i_rw`. RDY is ignored on write cycles. When `advance`=0, IR, TCU and `o_int_kind` hold.
- Fetch cycle (TCU==0, `advance`=1):
  - If `nmi_pending`: IR←`BRK_OPCODE`, `o_int_kind`←2, `nmi_pending` cleared.
  - Else if `i_irq` & ~`i_i_flag`: IR←`BRK_OPCODE`, `o_int_kind`←1.
  - Else: IR←`i_data`, `o_int_kind`←0.
  - In all three cases TCU←1. NMI has priority over IRQ.
- Other cycles (TCU≠0, `advance`=1):
  - If `i_last_cycle`: TCU←0.
  - Else if TCU==7: TCU←0 and pulse `o_tcu_overflow` (decoder fault; the next cycle is a fetch).
  - Else: TCU←`i_tcu_next`.
- NMI edge detect:
  - `nmi_prev`←`i_nmi` every cycle, including stalls.
  - On `i_nmi` & ~`nmi_prev`, `nmi_pending`←1, including during stalls.
  - If an edge arrives in the same cycle as injection clears `pending`, set wins and `pending` stays 1.
- `o_int_kind` holds until the next fetch overwrites it. The decoder uses a nonzero value to suppress PC increment and to convert the reset sequence's stack writes into reads.
- Reset values: `o_ir`=`BRK_OPCODE`, `o_tcu`=1, `o_sync`=0, `o_int_kind`=3, `o_tcu_overflow`=0, `nmi_pending`=0, `nmi_prev`=1. A high `i_nmi` at reset release therefore does not trigger an NMI. Reset mid-instruction discards all state and restarts the BRK sequence at TCU=1.

## Timing
- IR, TCU, `o_int_kind` and `o_tcu_overflow` are registered; `o_sync` decodes combinationally from the TCU register.
- The opcode sampled in the TCU==0 cycle appears on `o_ir` in the following cycle, together with `o_tcu`=1.
- Decoder feedback (`i_tcu_next`, `i_last_cycle`, `i_rw`) is combinational from `o_ir`/`o_tcu` and is used the same cycle. There are no combinational paths from these inputs to outputs.
- An instruction with last cycle N occupies N+1 clocks: TCU 0..N.
- NMI latency: an edge seen in any cycle is injected at the next TCU==0 cycle with `advance`=1, including a fetch occurring the cycle after the edge.
- `o_tcu_overflow` is high for exactly one clock, in the cycle after the wrap.

## Test plan
- Reset: hold `i_reset` 2 clocks with `i_nmi`=1 → `o_ir`=00, `o_tcu`=1, `o_int_kind`=3, `o_sync`=0. After release and with `i_nmi` held high, no NMI injected.
- STA abs:
  - Stimulus: at TCU=0, `i_data`=8D; decoder feeds `i_tcu_next`=TCU+1 and `i_last_cycle` at TCU=3.
  - Response: `o_ir`=8D; `o_tcu` runs 1,2,3,0; `o_sync`=1 exactly on the TCU=0 cycle.
- RDY: drop `i_rdy` for 3 clocks at TCU=2 with `i_rw`=1 → `o_tcu` stays 2 for 3 clocks. Drop `i_rdy` with `i_rw`=0 → TCU still advances.
- Interrupts:
  - 1-clock `i_nmi` pulse at TCU=2 → next fetch gives `o_ir`=00, `o_int_kind`=2, `i_data` ignored.
  - `i_irq`=1 with `i_i_flag`=1 → `o_ir`=`i_data`, `o_int_kind`=0. With `i_i_flag`=0 → `o_int_kind`=1.
  - NMI and IRQ together → 2.
- Overflow: decoder never asserts `i_last_cycle` → after TCU=7, `o_tcu`=0 with `o_tcu_overflow`=1 for one clock.
- Reset mid-instruction at TCU=3 of opcode 8D → next clock `o_ir`=00, `o_tcu`=1, `o_int_kind`=3, pending NMI cleared.
